redma_ctrl_slave: RTL and testbench
===================================

REDMA_CTRL_SLAVE -- requirements
Module: redma_ctrl_slave

Interface
REQ-001 SHALL have parameter DECODE_BITS, default 8, meaning the number of low awaddr bits used for register decode.
REQ-002 SHALL use one clock and a synchronous, active-high reset; the ports SHALL be named clk and rst.
REQ-003 SHALL provide these ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- io_control_aw_awaddr  in  32  write address
- io_control_aw_awprot  in  3  protection (ignored)
- io_control_aw_awvalid  in  1  address valid
- io_control_aw_awready  out  1  address accepted
- io_control_w_wdata  in  32  write data
- io_control_w_wstrb  in  4  byte strobes
- io_control_w_wvalid  in  1  data valid
- io_control_w_wready  out  1  data accepted
- io_control_b_bresp  out  2  response, OKAY=0, SLVERR=2
- io_control_b_bvalid  out  1  response valid
- io_control_b_bready  in  1  response accepted
- reader_done  in  1  reader completion pulse
- writer_done  in  1  writer completion pulse
- reader_start  out  1  one-cycle reader launch pulse
- writer_start  out  1  one-cycle writer launch pulse
- write_zero  out  1  registered write-zero mode
- reader_addr  out  32  reader start address register
- writer_addr  out  32  writer start address register
- btt  out  32  bytes-to-transfer register
- intr  out  1  level interrupt

Function
REQ-004 SHALL decode on awaddr[DECODE_BITS-1:2] and ignore upper and [1:0] bits.
- 0x00 START
- 0x04 ENABLE_INTR
- 0x0C CLEAR_INTR
- 0x10 READER_ADDR
- 0x20 WRITER_ADDR
- 0x30 BTT
REQ-005 SHALL accept AW and W independently into one-deep holding registers; awready=1 iff the AW holder is empty and no B is pending; wready likewise for the W holder.
REQ-006 SHALL commit the write in the cycle after both holders are full, and assert bvalid in the same cycle as the commit.
REQ-007 SHALL hold bvalid and bresp stable until bready; on the handshake it SHALL clear both holders, so awready and wready rise the next cycle.
REQ-008 SHALL sustain at most one write per 3 cycles with AW and W presented together and bready=1.
REQ-009 SHALL apply wstrb per byte to READER_ADDR, WRITER_ADDR, BTT and ENABLE_INTR[1:0]; an all-zero strobe SHALL update nothing and return OKAY.
REQ-010 On a START commit with wstrb[0]:
- data[0]=1 SHALL pulse reader_start for exactly one cycle;
- data[1]=1 SHALL pulse writer_start for exactly one cycle;
- write_zero SHALL be loaded from data[8] only if wstrb[1]=1.
REQ-011 SHALL keep busy_r/busy_w flags, set by a start pulse and cleared by the matching *_done.
REQ-012 A START request for an engine already busy SHALL not pulse that engine and SHALL return SLVERR; the other engine SHALL be unaffected.
REQ-013 A write to READER_ADDR, WRITER_ADDR or BTT while either engine is busy SHALL be dropped with SLVERR.
REQ-014 An unmapped address SHALL return SLVERR with no state change.
REQ-015 SHALL set pending[0] on reader_done and pending[1] on writer_done; a CLEAR_INTR write with data bit i=1 SHALL clear pending[i].
REQ-016 If set and clear of the same pending bit coincide, set SHALL win.
REQ-017 SHALL drive intr = |(pending & enable) as a registered output, one cycle after the cause.
REQ-018 A done for an engine that is not busy SHALL still set pending.

Reset
REQ-019 On rst=1 at a clock edge, the block SHALL clear all registers, holders, busy flags, pending and enable bits.
REQ-020 During reset, all outputs SHALL be 0: awready, wready, bvalid, bresp, start pulses, write_zero, reader_addr, writer_addr, btt, intr.
REQ-021 awready and wready SHALL rise on the first cycle after rst deasserts.
REQ-022 Reset mid-transaction SHALL discard held AW/W and any pending B without a response.

Structure
REQ-023 Package redma_ctrl_pkg SHALL hold the register offset constants, the BRESP codes, and the write-path state enum (IDLE, COMMIT, RESP).
REQ-024 Interrupt pending/enable logic SHALL live in a sub-module redma_intr_ctrl; all other logic SHALL be flat.

Verification
REQ-025 Bench SHALL cover:
- Full programming sequence (0x04<=2, 0x0C<=3, 0x10<=0x1000, 0x20<=0x2000, 0x30<=0x40, 0x00<=0x3): all OKAY; reader_addr=0x1000, writer_addr=0x2000, btt=0x40; both start pulses exactly one cycle.
- W presented 5 cycles before AW, then bready held low 4 cycles: bvalid stays high and stable, and no second AW is accepted until the B handshake.
- 0x00<=0x1 while reader busy: bresp=2, no reader_start.
- 0x10 write while busy: bresp=2, reader_addr unchanged.
- Write to 0x08: bresp=2, all registers unchanged.
- enable=2, writer_done pulse: intr=1 one cycle later; 0x0C<=2 together with a new writer_done: pending stays set, intr stays 1.
- rst asserted between AW acceptance and W: no bvalid ever issued; the next full write completes OKAY.

Source files
------------

// File: rtl/redma_ctrl_pkg.sv
// Shared constants, response codes and write-path state for the REDMA control slave.
package redma_ctrl_pkg;

    localparam logic [7:0] REG_START       = 8'h00;
    localparam logic [7:0] REG_ENABLE_INTR = 8'h04;
    localparam logic [7:0] REG_CLEAR_INTR  = 8'h0C;
    localparam logic [7:0] REG_READER_ADDR = 8'h10;
    localparam logic [7:0] REG_WRITER_ADDR = 8'h20;
    localparam logic [7:0] REG_BTT         = 8'h30;

    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_SLVERR = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COMMIT = 2'd1,
        RESP   = 2'd2
    } wr_state_e;

    // Byte-lane merge of new data into an existing 32-bit register.
    function automatic logic [31:0] strb_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[i*8 +: 8] = strb[i] ? new_v[i*8 +: 8] : old_v[i*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/redma_intr_ctrl.sv
// Interrupt pending/enable bookkeeping; intr is a registered OR of enabled pending causes.
module redma_intr_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       reader_done,
    input  logic       writer_done,
    input  logic       en_we,
    input  logic [1:0] en_data,
    input  logic [1:0] clr,
    output logic       intr
);

    logic [1:0] pending_r;
    logic [1:0] enable_r;
    logic [1:0] pending_n_s;
    logic [1:0] enable_n_s;
    logic       intr_r;

    // Next pending/enable values; a done arriving with a clear keeps the bit set.
    always_comb begin
        pending_n_s = (pending_r & ~clr) | {writer_done, reader_done};
        if (en_we) begin
            enable_n_s = en_data;
        end else begin
            enable_n_s = enable_r;
        end
    end

    // State registers and the registered interrupt level.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_r <= 2'b00;
            enable_r  <= 2'b00;
            intr_r    <= 1'b0;
        end else begin
            pending_r <= pending_n_s;
            enable_r  <= enable_n_s;
            intr_r    <= |(pending_n_s & enable_n_s);
        end
    end

    assign intr = intr_r;

endmodule

// File: rtl/redma_ctrl_slave.sv
// AXI-Lite write-only control slave for the REDMA engines: start pulses, address/length
// registers, busy tracking and the interrupt controller.
module redma_ctrl_slave
    import redma_ctrl_pkg::*;
#(
    parameter int DECODE_BITS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] io_control_aw_awaddr,
    input  logic [2:0]  io_control_aw_awprot,
    input  logic        io_control_aw_awvalid,
    output logic        io_control_aw_awready,
    input  logic [31:0] io_control_w_wdata,
    input  logic [3:0]  io_control_w_wstrb,
    input  logic        io_control_w_wvalid,
    output logic        io_control_w_wready,
    output logic [1:0]  io_control_b_bresp,
    output logic        io_control_b_bvalid,
    input  logic        io_control_b_bready,
    input  logic        reader_done,
    input  logic        writer_done,
    output logic        reader_start,
    output logic        writer_start,
    output logic        write_zero,
    output logic [31:0] reader_addr,
    output logic [31:0] writer_addr,
    output logic [31:0] btt,
    output logic        intr
);

    wr_state_e              state_r, state_n;
    logic                   aw_full_r, w_full_r, awready_r, wready_r;
    logic [DECODE_BITS-1:2] aw_addr_r;
    logic [31:0]            w_data_r;
    logic [3:0]             w_strb_r;
    logic                   bvalid_r;
    logic [1:0]             bresp_r;
    logic                   reader_start_r, writer_start_r, write_zero_r;
    logic                   busy_rd_r, busy_wr_r;
    logic [31:0]            reader_addr_r, writer_addr_r, btt_r;

    logic                   aw_acc_s, w_acc_s, b_hs_s, aw_full_n_s, w_full_n_s, commit_s;
    logic [DECODE_BITS-1:0] reg_off_s;
    logic                   regs_busy_s;
    logic [1:0]             resp_s, clr_s;
    logic                   rd_go_s, wr_go_s, wz_we_s, ra_we_s, wa_we_s, btt_we_s, en_we_s;
    logic                   unused_s;

    assign unused_s = ^{io_control_aw_awprot, io_control_aw_awaddr[31:DECODE_BITS],
                        io_control_aw_awaddr[1:0]};

    assign aw_acc_s    = io_control_aw_awvalid & awready_r;
    assign w_acc_s     = io_control_w_wvalid & wready_r;
    assign b_hs_s      = bvalid_r & io_control_b_bready;
    assign aw_full_n_s = b_hs_s ? 1'b0 : (aw_full_r | aw_acc_s);
    assign w_full_n_s  = b_hs_s ? 1'b0 : (w_full_r | w_acc_s);
    assign commit_s    = (state_r == COMMIT);
    assign reg_off_s   = {aw_addr_r, 2'b00};
    assign regs_busy_s = busy_rd_r | busy_wr_r;

    // Write-path sequencing: wait for both holders, commit once, hold B until accepted.
    always_comb begin
        state_n = state_r;
        case (state_r)
            IDLE: begin
                if (aw_full_n_s && w_full_n_s) begin
                    state_n = COMMIT;
                end else begin
                    state_n = IDLE;
                end
            end
            COMMIT:  state_n = RESP;
            RESP: begin
                if (b_hs_s) begin
                    state_n = IDLE;
                end else begin
                    state_n = RESP;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Register decode and response selection for the held write.
    always_comb begin
        resp_s   = RESP_OKAY;
        rd_go_s  = 1'b0;
        wr_go_s  = 1'b0;
        wz_we_s  = 1'b0;
        ra_we_s  = 1'b0;
        wa_we_s  = 1'b0;
        btt_we_s = 1'b0;
        en_we_s  = 1'b0;
        clr_s    = 2'b00;
        case (reg_off_s)
            DECODE_BITS'(REG_START): begin
                rd_go_s = w_strb_r[0] & w_data_r[0] & ~busy_rd_r;
                wr_go_s = w_strb_r[0] & w_data_r[1] & ~busy_wr_r;
                wz_we_s = w_strb_r[1];
                if (w_strb_r[0] & ((w_data_r[0] & busy_rd_r) | (w_data_r[1] & busy_wr_r))) begin
                    resp_s = RESP_SLVERR;
                end else begin
                    resp_s = RESP_OKAY;
                end
            end
            DECODE_BITS'(REG_ENABLE_INTR): en_we_s = w_strb_r[0];
            DECODE_BITS'(REG_CLEAR_INTR):  clr_s   = w_strb_r[0] ? w_data_r[1:0] : 2'b00;
            DECODE_BITS'(REG_READER_ADDR): begin
                if (regs_busy_s && (w_strb_r != 4'b0000)) begin
                    resp_s = RESP_SLVERR;
                end else begin
                    ra_we_s = 1'b1;
                end
            end
            DECODE_BITS'(REG_WRITER_ADDR): begin
                if (regs_busy_s && (w_strb_r != 4'b0000)) begin
                    resp_s = RESP_SLVERR;
                end else begin
                    wa_we_s = 1'b1;
                end
            end
            DECODE_BITS'(REG_BTT): begin
                if (regs_busy_s && (w_strb_r != 4'b0000)) begin
                    resp_s = RESP_SLVERR;
                end else begin
                    btt_we_s = 1'b1;
                end
            end
            default: resp_s = RESP_SLVERR;
        endcase
    end

    // Holders, response channel, control registers and engine busy flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= IDLE;
            aw_full_r      <= 1'b0;
            w_full_r       <= 1'b0;
            awready_r      <= 1'b0;
            wready_r       <= 1'b0;
            aw_addr_r      <= '0;
            w_data_r       <= 32'h0000_0000;
            w_strb_r       <= 4'b0000;
            bvalid_r       <= 1'b0;
            bresp_r        <= RESP_OKAY;
            reader_start_r <= 1'b0;
            writer_start_r <= 1'b0;
            write_zero_r   <= 1'b0;
            busy_rd_r      <= 1'b0;
            busy_wr_r      <= 1'b0;
            reader_addr_r  <= 32'h0000_0000;
            writer_addr_r  <= 32'h0000_0000;
            btt_r          <= 32'h0000_0000;
        end else begin
            state_r   <= state_n;
            aw_full_r <= aw_full_n_s;
            w_full_r  <= w_full_n_s;
            awready_r <= ~aw_full_n_s;
            wready_r  <= ~w_full_n_s;
            if (aw_acc_s) aw_addr_r <= io_control_aw_awaddr[DECODE_BITS-1:2];
            if (w_acc_s) begin
                w_data_r <= io_control_w_wdata;
                w_strb_r <= io_control_w_wstrb;
            end
            if (commit_s) begin
                bvalid_r <= 1'b1;
                bresp_r  <= resp_s;
            end else if (b_hs_s) begin
                bvalid_r <= 1'b0;
                bresp_r  <= RESP_OKAY;
            end
            reader_start_r <= commit_s & rd_go_s;
            writer_start_r <= commit_s & wr_go_s;
            if (commit_s && wz_we_s)  write_zero_r  <= w_data_r[8];
            if (commit_s && ra_we_s)  reader_addr_r <= strb_merge(reader_addr_r, w_data_r, w_strb_r);
            if (commit_s && wa_we_s)  writer_addr_r <= strb_merge(writer_addr_r, w_data_r, w_strb_r);
            if (commit_s && btt_we_s) btt_r         <= strb_merge(btt_r, w_data_r, w_strb_r);
            if (commit_s && rd_go_s)  busy_rd_r <= 1'b1;
            else if (reader_done)     busy_rd_r <= 1'b0;
            if (commit_s && wr_go_s)  busy_wr_r <= 1'b1;
            else if (writer_done)     busy_wr_r <= 1'b0;
        end
    end

    redma_intr_ctrl u_intr (
        .clk         (clk),
        .rst         (rst),
        .reader_done (reader_done),
        .writer_done (writer_done),
        .en_we       (commit_s & en_we_s),
        .en_data     (w_data_r[1:0]),
        .clr         (commit_s ? clr_s : 2'b00),
        .intr        (intr)
    );

    assign io_control_aw_awready = awready_r;
    assign io_control_w_wready   = wready_r;
    assign io_control_b_bvalid   = bvalid_r;
    assign io_control_b_bresp    = bresp_r;
    assign reader_start          = reader_start_r;
    assign writer_start          = writer_start_r;
    assign write_zero            = write_zero_r;
    assign reader_addr           = reader_addr_r;
    assign writer_addr           = writer_addr_r;
    assign btt                   = btt_r;

endmodule

// File: tb/tb_redma_ctrl_slave.sv
// Self-checking bench for redma_ctrl_slave: directed scenarios plus randomized AXI-Lite
// writes compared every cycle against a transaction-level model of the register file.
module tb_redma_ctrl_slave;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] io_control_aw_awaddr;
    logic [2:0]  io_control_aw_awprot;
    logic        io_control_aw_awvalid, io_control_aw_awready;
    logic [31:0] io_control_w_wdata;
    logic [3:0]  io_control_w_wstrb;
    logic        io_control_w_wvalid, io_control_w_wready;
    logic [1:0]  io_control_b_bresp;
    logic        io_control_b_bvalid, io_control_b_bready;
    logic        reader_done, writer_done, reader_start, writer_start, write_zero, intr;
    logic [31:0] reader_addr, writer_addr, btt;

    always #5 clk = ~clk;

    redma_ctrl_slave #(.DECODE_BITS(8)) dut (
        .clk(clk), .rst(rst),
        .io_control_aw_awaddr(io_control_aw_awaddr), .io_control_aw_awprot(io_control_aw_awprot),
        .io_control_aw_awvalid(io_control_aw_awvalid), .io_control_aw_awready(io_control_aw_awready),
        .io_control_w_wdata(io_control_w_wdata), .io_control_w_wstrb(io_control_w_wstrb),
        .io_control_w_wvalid(io_control_w_wvalid), .io_control_w_wready(io_control_w_wready),
        .io_control_b_bresp(io_control_b_bresp), .io_control_b_bvalid(io_control_b_bvalid),
        .io_control_b_bready(io_control_b_bready),
        .reader_done(reader_done), .writer_done(writer_done),
        .reader_start(reader_start), .writer_start(writer_start), .write_zero(write_zero),
        .reader_addr(reader_addr), .writer_addr(writer_addr), .btt(btt), .intr(intr)
    );

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;
    bit rand_en = 1'b0;
    int rs_cnt = 0, ws_cnt = 0, bv_cnt = 0;
    longint last_b_time = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_aw_full, m_w_full, m_awready, m_wready, m_bvalid;
    logic [31:0] m_addr, m_data;
    logic [3:0]  m_strb;
    logic [1:0]  m_bresp, m_pend, m_en;
    bit          m_rs, m_ws, m_wz, m_busy_rd, m_busy_wr, m_intr;
    logic [31:0] m_ra, m_wa, m_btt;

    task automatic model_step();
        logic [7:0] off;
        logic [1:0] resp, clr;
        bit hs, aw_acc, w_acc, commit, go_r, go_w;
        if (rst) begin
            {m_aw_full, m_w_full, m_awready, m_wready, m_bvalid} = '0;
            {m_rs, m_ws, m_wz, m_busy_rd, m_busy_wr, m_intr} = '0;
            m_bresp = 2'd0; m_pend = 2'd0; m_en = 2'd0;
            m_ra = 32'd0; m_wa = 32'd0; m_btt = 32'd0;
            return;
        end
        hs     = m_bvalid && io_control_b_bready;
        aw_acc = io_control_aw_awvalid && m_awready;
        w_acc  = io_control_w_wvalid && m_wready;
        commit = m_aw_full && m_w_full && !m_bvalid;
        go_r = 0; go_w = 0; clr = 2'd0; resp = 2'd0;
        if (commit) begin
            off = {m_addr[7:2], 2'b00};
            if (off == 8'h00) begin
                if (m_strb[0]) begin
                    go_r = m_data[0] && !m_busy_rd;
                    go_w = m_data[1] && !m_busy_wr;
                    if ((m_data[0] && m_busy_rd) || (m_data[1] && m_busy_wr)) resp = 2'd2;
                end
                if (m_strb[1]) m_wz = m_data[8];
            end else if (off == 8'h04) begin
                if (m_strb[0]) m_en = m_data[1:0];
            end else if (off == 8'h0C) begin
                if (m_strb[0]) clr = m_data[1:0];
            end else if (off == 8'h10 || off == 8'h20 || off == 8'h30) begin
                if (m_strb != 4'd0 && (m_busy_rd || m_busy_wr)) resp = 2'd2;
                else begin
                    for (int i = 0; i < 4; i++) begin
                        if (m_strb[i]) begin
                            if (off == 8'h10)      m_ra[8*i +: 8]  = m_data[8*i +: 8];
                            else if (off == 8'h20) m_wa[8*i +: 8]  = m_data[8*i +: 8];
                            else                   m_btt[8*i +: 8] = m_data[8*i +: 8];
                        end
                    end
                end
            end else begin
                resp = 2'd2;
            end
        end
        m_pend    = (m_pend & ~clr) | {writer_done, reader_done};
        m_busy_rd = go_r ? 1'b1 : (reader_done ? 1'b0 : m_busy_rd);
        m_busy_wr = go_w ? 1'b1 : (writer_done ? 1'b0 : m_busy_wr);
        m_rs = go_r; m_ws = go_w;
        m_intr = |(m_pend & m_en);
        if (commit) begin m_bvalid = 1'b1; m_bresp = resp; end
        else if (hs) m_bvalid = 1'b0;
        if (hs) begin m_aw_full = 1'b0; m_w_full = 1'b0; end
        if (aw_acc) begin m_aw_full = 1'b1; m_addr = io_control_aw_awaddr; end
        if (w_acc) begin m_w_full = 1'b1; m_data = io_control_w_wdata; m_strb = io_control_w_wstrb; end
        m_awready = !m_aw_full;
        m_wready  = !m_w_full;
    endtask

    always @(posedge clk) model_step();

    // B-channel stability reference: what happened at the last edge.
    bit p_bv, p_hs;
    logic [1:0] p_br;
    always @(posedge clk) begin
        p_bv <= io_control_b_bvalid && !rst;
        p_hs <= io_control_b_bvalid && io_control_b_bready;
        p_br <= io_control_b_bresp;
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("awready", io_control_aw_awready, m_awready);
            chk("wready", io_control_w_wready, m_wready);
            chk("bvalid", io_control_b_bvalid, m_bvalid);
            if (m_bvalid) chk("bresp", io_control_b_bresp, m_bresp);
            chk("reader_start", reader_start, m_rs);
            chk("writer_start", writer_start, m_ws);
            chk("write_zero", write_zero, m_wz);
            chk("reader_addr", reader_addr, m_ra);
            chk("writer_addr", writer_addr, m_wa);
            chk("btt", btt, m_btt);
            chk("intr", intr, m_intr);
            if (p_bv && !p_hs) begin
                chk("bvalid_hold", io_control_b_bvalid, 1'b1);
                chk("bresp_hold", io_control_b_bresp, p_br);
            end
        end
        if (reader_start === 1'b1) rs_cnt++;
        if (writer_start === 1'b1) ws_cnt++;
        if (io_control_b_bvalid === 1'b1) bv_cnt++;
    end

    function automatic bit rnd_done();
        return rand_en && ($urandom_range(0, 11) == 0);
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            io_control_aw_awvalid = 1'b0;
            io_control_w_wvalid   = 1'b0;
            io_control_b_bready   = 1'b0;
            reader_done = rnd_done();
            writer_done = rnd_done();
        end
    endtask

    // One complete write; aw/w delays in cycles, bready held low b_dly cycles of bvalid.
    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int aw_dly, input int w_dly, input int b_dly,
                             input int done_at, input logic [1:0] done_mask,
                             output logic [1:0] resp, output int b_cycles);
        int t = 0, bcnt = 0;
        bit aw_s = 0, w_s = 0, b_g = 0;
        logic ar, wr, bv;
        logic [1:0] br;
        resp = 2'bxx;
        while (!b_g && t < 100) begin
            @(negedge clk);
            io_control_aw_awaddr  = addr;
            io_control_aw_awprot  = 3'($urandom_range(0, 7));
            io_control_w_wdata    = data;
            io_control_w_wstrb    = strb;
            io_control_aw_awvalid = !aw_s && (t >= aw_dly);
            io_control_w_wvalid   = !w_s && (t >= w_dly);
            io_control_b_bready   = io_control_b_bvalid && (bcnt >= b_dly);
            if (io_control_b_bvalid) bcnt++;
            reader_done = (t == done_at) ? done_mask[0] : rnd_done();
            writer_done = (t == done_at) ? done_mask[1] : rnd_done();
            ar = io_control_aw_awready; wr = io_control_w_wready;
            bv = io_control_b_bvalid;   br = io_control_b_bresp;
            @(posedge clk);
            if (io_control_aw_awvalid && ar) aw_s = 1'b1;
            if (io_control_w_wvalid && wr)   w_s = 1'b1;
            if (bv && io_control_b_bready) begin
                b_g = 1'b1; resp = br; last_b_time = $time;
            end
            t++;
        end
        b_cycles = bcnt;
        chk("b_handshake_within_budget", b_g, 1'b1);
    endtask

    logic [1:0]  resp;
    int          bc, rs0, ws0, bv0;
    longint      t1;
    logic [31:0] prog_a[6] = '{32'h04, 32'h0C, 32'h10, 32'h20, 32'h30, 32'h00};
    logic [31:0] prog_d[6] = '{32'h2, 32'h3, 32'h1000, 32'h2000, 32'h40, 32'h3};
    logic [7:0]  offs[7]   = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h20, 8'h30};

    initial begin
        rst = 1'b1;
        io_control_aw_awaddr = 32'd0; io_control_aw_awprot = 3'd0; io_control_aw_awvalid = 1'b0;
        io_control_w_wdata = 32'd0; io_control_w_wstrb = 4'd0; io_control_w_wvalid = 1'b0;
        io_control_b_bready = 1'b0; reader_done = 1'b0; writer_done = 1'b0;
        @(posedge clk);
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_awready", io_control_aw_awready, 1'b0);
        chk("rst_bvalid", io_control_b_bvalid, 1'b0);
        chk("rst_btt", btt, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("awready_after_rst", io_control_aw_awready, 1'b1);
        chk("wready_after_rst", io_control_w_wready, 1'b1);

        // Full programming sequence
        rs0 = rs_cnt; ws0 = ws_cnt;
        for (int i = 0; i < 6; i++) begin
            axi_write(prog_a[i], prog_d[i], 4'hF, 0, 0, 0, -1, 2'b00, resp, bc);
            chk("prog_resp", resp, 2'd0);
        end
        idle(3);
        chk("prog_reader_addr", reader_addr, 32'h1000);
        chk("prog_writer_addr", writer_addr, 32'h2000);
        chk("prog_btt", btt, 32'h40);
        chk("prog_reader_start_cycles", rs_cnt - rs0, 1);
        chk("prog_writer_start_cycles", ws_cnt - ws0, 1);

        // Both engines busy now
        rs0 = rs_cnt;
        axi_write(32'h00, 32'h1, 4'hF, 0, 0, 0, -1, 2'b00, resp, bc);
        chk("busy_start_resp", resp, 2'd2);
        axi_write(32'h10, 32'h5555, 4'hF, 0, 0, 0, -1, 2'b00, resp, bc);
        chk("busy_addr_resp", resp, 2'd2);
        axi_write(32'h08, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, -1, 2'b00, resp, bc);
        chk("unmapped_resp", resp, 2'd2);
        idle(2);
        chk("busy_no_reader_start", rs_cnt - rs0, 0);
        chk("busy_reader_addr_kept", reader_addr, 32'h1000);
        chk("unmapped_btt_kept", btt, 32'h40);

        // Interrupt: enable=2, writer_done -> intr one cycle later
        @(negedge clk);
        chk("intr_before_done", intr, 1'b0);
        reader_done = 1'b1; writer_done = 1'b1;
        @(negedge clk);
        reader_done = 1'b0; writer_done = 1'b0;
        chk("intr_after_done", intr, 1'b1);
        axi_write(32'h0C, 32'h2, 4'hF, 0, 0, 0, 1, 2'b10, resp, bc);
        idle(1);
        chk("intr_set_wins", intr, 1'b1);
        axi_write(32'h0C, 32'h2, 4'hF, 0, 0, 0, -1, 2'b00, resp, bc);
        idle(1);
        chk("intr_cleared", intr, 1'b0);

        // W five cycles ahead of AW, bready low four cycles
        axi_write(32'h30, 32'h80, 4'hF, 5, 0, 4, -1, 2'b00, resp, bc);
        chk("wlead_resp", resp, 2'd0);
        chk("wlead_bvalid_cycles", bc, 5);
        chk("wlead_btt", btt, 32'h80);

        // Back-to-back throughput
        axi_write(32'h30, 32'h90, 4'hF, 0, 0, 0, -1, 2'b00, resp, bc);
        t1 = last_b_time;
        axi_write(32'h30, 32'hA0, 4'hF, 0, 0, 0, -1, 2'b00, resp, bc);
        chk("throughput_3_cycles", 32'(last_b_time - t1), 32'd30);

        // Reset between AW acceptance and W
        bv0 = bv_cnt;
        @(negedge clk);
        io_control_aw_awaddr = 32'h10; io_control_aw_awvalid = 1'b1;
        io_control_w_wvalid = 1'b0; io_control_b_bready = 1'b1;
        @(negedge clk);
        io_control_aw_awvalid = 1'b0;
        chk("aw_held_before_rst", io_control_aw_awready, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk("in_rst_wready", io_control_w_wready, 1'b0);
        chk("in_rst_write_zero", write_zero, 1'b0);
        chk("in_rst_btt", btt, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("awready_after_mid_rst", io_control_aw_awready, 1'b1);
        idle(4);
        chk("no_bvalid_after_rst", bv_cnt - bv0, 0);
        axi_write(32'h10, 32'h00AB_CD00, 4'hF, 0, 0, 0, -1, 2'b00, resp, bc);
        chk("post_rst_resp", resp, 2'd0);
        chk("post_rst_reader_addr", reader_addr, 32'h00AB_CD00);

        // Randomized traffic
        rand_en = 1'b1;
        for (int n = 0; n < 300; n++) begin
            logic [31:0] a;
            logic [3:0]  s;
            a = $urandom;
            a[7:0] = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : offs[$urandom_range(0, 6)];
            if ($urandom_range(0, 1) == 0) a[31:8] = 24'h0;
            a[1:0] = 2'($urandom_range(0, 3));
            s = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
            axi_write(a, $urandom, s, $urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom_range(0, 2), -1, 2'b00, resp, bc);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 4));
        end
        rand_en = 1'b0;
        idle(3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
